mac_accum: RTL and testbench
============================

Name: mac_accum

Overview:
- Sequential accumulator stage directly downstream of the team's 4x4 combinational array multiplier.
- Sums a programmed number of 8-bit products into a wider accumulator.
- Product input and result output each use a valid/ready handshake.
- Provides the multiply-accumulate path for dot-product and filter datapaths built on the 4x4 multiplier.

Parameters:
PROD_W, 8, width of incoming product (2 x 4-bit operand width)
ACC_W, 10, accumulator/result width; must be >= PROD_W
CNT_W, 4, width of term-count field; maximum run length 2**CNT_W terms

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a new accumulation run; sampled only in IDLE
num_terms  in  CNT_W  products to sum; 0 means 2**CNT_W
prod_valid  in  1  product beat valid
prod  in  PROD_W  unsigned product from multiplier
prod_ready  out  1  stage accepts a product this cycle
res_valid  out  1  result available
res  out  ACC_W  accumulated sum
res_ready  in  1  consumer takes result
busy  out  1  high in ACC or DONE
ovf  out  1  sticky: carry out of ACC_W occurred in the current or last run

Behaviour:
- Interface fixed: one clock `clk`; `rst` is asynchronous and active-high.
- Reset values, asserted on any rst edge including mid-run: state=IDLE; acc, count and target = 0; prod_ready=0, res_valid=0, res=0, busy=0, ovf=0.
- Run states: IDLE -> ACC -> DONE -> IDLE.
- IDLE:
  - prod_ready=0.
  - start=1: latch target=(num_terms==0 ? 2**CNT_W : num_terms), clear acc, count and ovf, go to ACC next cycle.
  - Product beats presented in IDLE are not accepted; no data is lost because prod_ready=0.
- ACC:
  - prod_ready=1 combinationally from state only, with no dependency on prod_valid.
  - Accept beat when prod_valid & prod_ready: acc <= acc + zero-extended prod; count <= count+1.
  - Beat that makes count equal target: go to DONE next cycle.
  - Idle cycles (prod_valid=0) leave acc and count unchanged.
  - start is ignored outside IDLE.
- DONE:
  - res_valid=1 and res=acc, held stable until handshake; prod_ready=0.
  - res_valid & res_ready: go to IDLE next cycle.
  - start in the same cycle as the handshake is ignored. A new run requires start while in IDLE.
- Latency: res_valid rises on the cycle after the last product is accepted. Minimum run of N terms = 1 (start) + N + 1 (DONE) cycles.
- Arithmetic: unsigned; sum computed at ACC_W+1 bits. Carry out sets ovf (sticky until next start). Without saturation, acc wraps modulo 2**ACC_W.
- res is driven by the registered acc and is valid only while res_valid=1. acc holds its value in IDLE until the next start.

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined: on carry out, acc saturates to all-ones (2**ACC_W-1) and stays there for the rest of the run; ovf still sets.
- Undefined: modulo wrap as above; ovf is the only overflow indication.

Decomposition:
- Shared package:
  - state enum {IDLE, ACC, DONE}
  - default width constants PROD_W=8, ACC_W=10, CNT_W=4
  - function computing the effective target from num_terms
- One sub-module is natural: mac_acc_dp, the datapath. It holds the ACC_W register, the adder with carry, saturation mux under MAC_SAT_EN, and the ovf flag.
- mac_accum keeps the FSM and counter, and instantiates mac_acc_dp.

Test Plan:
- Basic sum: start with num_terms=4; products 15,225,1,0 back-to-back; res_ready=1 -> res_valid one cycle after 4th beat, res=241, ovf=0.
- Overflow: num_terms=5, five beats of 225 (sum 1125):
  - MAC_SAT_EN undefined -> res=101, ovf=1.
  - MAC_SAT_EN defined -> res=1023, ovf=1.
- Bubbles and backpressure: num_terms=3 with prod_valid gaps of 2 cycles; res_ready held 0 for 5 cycles -> res=sum held stable, res_valid high throughout; IDLE entered the cycle after res_ready=1.
- Zero count: num_terms=0 -> exactly 16 beats accepted (16 x 60 = 960); 17th beat sees prod_ready=0; res=960.
- Start ignored: pulse start during ACC and during DONE -> no change to count, acc or target; prod_valid in IDLE -> prod_ready=0, nothing accumulated.
- Async reset mid-run: assert rst after 2 of 4 beats, between clock edges -> all outputs 0 immediately. Then a fresh start with num_terms=1, prod=7 -> res=7, ovf=0.

Source files
------------

// File: rtl/mac_accum_pkg.sv
// Shared types and constants for the multiply-accumulate stage.
// Holds the run-state enum, the default datapath widths and the helper
// that turns a programmed term count into the number of beats to sum.
package mac_accum_pkg;

  localparam int DEF_PROD_W = 8;
  localparam int DEF_ACC_W  = 10;
  localparam int DEF_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A programmed count of zero stands for the longest run, 2**cnt_w terms.
  function automatic int eff_target(input int num, input int cnt_w);
    return (num == 0) ? (1 << cnt_w) : num;
  endfunction

endpackage

// File: rtl/mac_accum_if.sv
// Handshake bundle between a multiplier-side producer and mac_accum.
// The master side drives start/num_terms/products and takes the result;
// the slave side (the accumulator) answers with ready, result and status.
interface mac_accum_if #(
  parameter int PROD_W = mac_accum_pkg::DEF_PROD_W,
  parameter int ACC_W  = mac_accum_pkg::DEF_ACC_W,
  parameter int CNT_W  = mac_accum_pkg::DEF_CNT_W
);

  logic              start;
  logic [CNT_W-1:0]  num_terms;
  logic              prod_valid;
  logic [PROD_W-1:0] prod;
  logic              prod_ready;
  logic              res_valid;
  logic [ACC_W-1:0]  res;
  logic              res_ready;
  logic              busy;
  logic              ovf;

  modport master (
    output start, num_terms, prod_valid, prod, res_ready,
    input  prod_ready, res_valid, res, busy, ovf
  );

  modport slave (
    input  start, num_terms, prod_valid, prod, res_ready,
    output prod_ready, res_valid, res, busy, ovf
  );

endinterface

// File: rtl/mac_acc_dp.sv
// Accumulator datapath: ACC_W register, adder with carry out, sticky ovf.
// With MAC_SAT_EN defined a carry clamps the sum to all-ones; otherwise it wraps.
// Both the register and ovf clear on clr_i and update only on add_i.
module mac_acc_dp #(
  parameter int PROD_W = mac_accum_pkg::DEF_PROD_W,
  parameter int ACC_W  = mac_accum_pkg::DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              ovf_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic             ovf_q;
  logic [ACC_W:0]   sum;
  logic             carry;

  // One extra bit on the adder exposes the carry out of the accumulator.
  assign sum   = {1'b0, acc_q} + (ACC_W+1)'(prod_i);
  assign carry = sum[ACC_W];

`ifdef MAC_SAT_EN
  // Once clamped, any further non-zero add carries again, so the value sticks.
  assign acc_d = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_d = sum[ACC_W-1:0];
`endif

  // Accumulator and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr_i) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (add_i) begin
      acc_q <= acc_d;
      if (carry) ovf_q <= 1'b1;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/mac_accum.sv
// Sums a programmed number of multiplier products (IDLE -> ACC -> DONE -> IDLE).
// Latency: result valid the cycle after the last product beat is accepted.
// Products are only accepted in ACC; the result holds in DONE until res_ready.
// Optional clamp-on-overflow behaviour is selected by the MAC_SAT_EN macro.
module mac_accum #(
  parameter int PROD_W = mac_accum_pkg::DEF_PROD_W,
  parameter int ACC_W  = mac_accum_pkg::DEF_ACC_W,
  parameter int CNT_W  = mac_accum_pkg::DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  mac_accum_if.slave     bus
);

  import mac_accum_pkg::*;

  state_e           state_q;
  logic [CNT_W:0]   cnt_q;
  logic [CNT_W:0]   cnt_d;
  logic [CNT_W:0]   tgt_q;
  logic [CNT_W:0]   tgt_d;
  logic             accept;
  logic             clr;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  // Count/target carry one extra bit so a full 2**CNT_W run is representable.
  assign cnt_d  = cnt_q + 1'b1;
  assign tgt_d  = (CNT_W+1)'(eff_target(int'(bus.num_terms), CNT_W));
  assign accept = (state_q == ACC) && bus.prod_valid;
  assign clr    = (state_q == IDLE) && bus.start;

  // Run-control FSM with beat counter; start is honoured only in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            tgt_q   <= tgt_d;
            cnt_q   <= '0;
            state_q <= ACC;
          end
        end
        ACC: begin
          if (accept) begin
            cnt_q <= cnt_d;
            if (cnt_d == tgt_q) state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mac_acc_dp #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .add_i  (accept),
    .prod_i (bus.prod),
    .acc_o  (acc),
    .ovf_o  (ovf)
  );

  // Handshake and status outputs decode straight from the state register.
  assign bus.prod_ready = (state_q == ACC);
  assign bus.res_valid  = (state_q == DONE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.res        = acc;
  assign bus.ovf        = ovf;

endmodule

// File: tb/tb_mac_accum.sv
// Directed bench for mac_accum: table of runs plus hand-built corner sequences.
// Checks reset state, sums, overflow (wrap or clamp), bubbles, backpressure,
// start suppression, IDLE product rejection and asynchronous mid-run reset.
module tb_mac_accum;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  mac_accum_if bus ();

  mac_accum dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       nt;
    int               beats;
    logic [15:0][7:0] p;
    logic [9:0]       exp_res;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [3:0] nt);
    bus.start     = 1'b1;
    bus.num_terms = nt;
    tick();
    bus.start     = 1'b0;
  endtask

  // Back-to-back run with res_ready already high.
  task automatic run_vec(input vec_t v, input int idx);
    start_run(v.nt);
    chk($sformatf("v%0d busy_in_acc", idx), 32'(bus.busy), 32'd1);
    for (int i = 0; i < v.beats; i++) begin
      bus.prod_valid = 1'b1;
      bus.prod       = v.p[i];
      chk($sformatf("v%0d prod_ready_beat%0d", idx, i), 32'(bus.prod_ready), 32'd1);
      chk($sformatf("v%0d res_valid_beat%0d", idx, i), 32'(bus.res_valid), 32'd0);
      tick();
    end
    // One more beat is offered; DONE must refuse it.
    chk($sformatf("v%0d res_valid", idx), 32'(bus.res_valid), 32'd1);
    chk($sformatf("v%0d res", idx), 32'(bus.res), 32'(v.exp_res));
    chk($sformatf("v%0d ovf", idx), 32'(bus.ovf), 32'(v.exp_ovf));
    chk($sformatf("v%0d prod_ready_done", idx), 32'(bus.prod_ready), 32'd0);
    tick();
    bus.prod_valid = 1'b0;
    chk($sformatf("v%0d busy_after", idx), 32'(bus.busy), 32'd0);
    chk($sformatf("v%0d res_valid_after", idx), 32'(bus.res_valid), 32'd0);
    chk($sformatf("v%0d res_held_idle", idx), 32'(bus.res), 32'(v.exp_res));
  endtask

  task automatic beat(input logic [7:0] val);
    bus.prod_valid = 1'b1;
    bus.prod       = val;
    tick();
    bus.prod_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.num_terms  = '0;
    bus.prod_valid = 1'b0;
    bus.prod       = '0;
    bus.res_ready  = 1'b1;

    for (int k = 0; k < 6; k++) begin
      vecs[k].p = '0;
    end
    vecs[0].nt = 4'd4; vecs[0].beats = 4;
    vecs[0].p[0] = 8'd15; vecs[0].p[1] = 8'd225; vecs[0].p[2] = 8'd1; vecs[0].p[3] = 8'd0;
    vecs[0].exp_res = 10'd241; vecs[0].exp_ovf = 1'b0;
    vecs[1].nt = 4'd5; vecs[1].beats = 5;
    for (int i = 0; i < 5; i++) vecs[1].p[i] = 8'd225;
`ifdef MAC_SAT_EN
    vecs[1].exp_res = 10'd1023;
`else
    vecs[1].exp_res = 10'd101;
`endif
    vecs[1].exp_ovf = 1'b1;
    vecs[2].nt = 4'd0; vecs[2].beats = 16;
    for (int i = 0; i < 16; i++) vecs[2].p[i] = 8'd60;
    vecs[2].exp_res = 10'd960; vecs[2].exp_ovf = 1'b0;
    vecs[3].nt = 4'd15; vecs[3].beats = 15;
    for (int i = 0; i < 15; i++) vecs[3].p[i] = 8'd68;
    vecs[3].exp_res = 10'd1020; vecs[3].exp_ovf = 1'b0;
    vecs[4].nt = 4'd0; vecs[4].beats = 16;
    for (int i = 0; i < 16; i++) vecs[4].p[i] = 8'd64;
`ifdef MAC_SAT_EN
    vecs[4].exp_res = 10'd1023;
`else
    vecs[4].exp_res = 10'd0;
`endif
    vecs[4].exp_ovf = 1'b1;
    vecs[5].nt = 4'd2; vecs[5].beats = 2;
    vecs[5].p[0] = 8'd255; vecs[5].p[1] = 8'd255;
    vecs[5].exp_res = 10'd510; vecs[5].exp_ovf = 1'b0;

    // Reset state while rst is held.
    #12;
    chk("rst prod_ready", 32'(bus.prod_ready), 32'd0);
    chk("rst res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst res", 32'(bus.res), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 6; k++) begin
      run_vec(vecs[k], k);
    end

    // Bubbles of two cycles and five cycles of result backpressure.
    bus.res_ready = 1'b0;
    start_run(4'd3);
    beat(8'd10);
    for (int g = 0; g < 2; g++) begin
      chk("bub prod_ready_gap1", 32'(bus.prod_ready), 32'd1);
      tick();
    end
    beat(8'd20);
    for (int g = 0; g < 2; g++) begin
      chk("bub res_valid_gap2", 32'(bus.res_valid), 32'd0);
      tick();
    end
    beat(8'd30);
    for (int h = 0; h < 5; h++) begin
      chk($sformatf("bp res_valid_c%0d", h), 32'(bus.res_valid), 32'd1);
      chk($sformatf("bp res_c%0d", h), 32'(bus.res), 32'd60);
      tick();
    end
    bus.res_ready = 1'b1;
    chk("bp res_valid_before_hs", 32'(bus.res_valid), 32'd1);
    tick();
    chk("bp busy_after_hs", 32'(bus.busy), 32'd0);
    chk("bp res_valid_after_hs", 32'(bus.res_valid), 32'd0);

    // start ignored in ACC and in DONE.
    bus.res_ready = 1'b0;
    start_run(4'd2);
    beat(8'd5);
    bus.start     = 1'b1;
    bus.num_terms = 4'd7;
    tick();
    bus.start     = 1'b0;
    chk("sig busy_in_acc", 32'(bus.busy), 32'd1);
    chk("sig res_after_restart", 32'(bus.res), 32'd5);
    beat(8'd6);
    chk("sig done_after_2", 32'(bus.res_valid), 32'd1);
    chk("sig res", 32'(bus.res), 32'd11);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("sig still_done", 32'(bus.res_valid), 32'd1);
    chk("sig res_done", 32'(bus.res), 32'd11);
    bus.start     = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("sig idle_after_hs", 32'(bus.busy), 32'd0);
    tick();
    chk("sig no_restart", 32'(bus.busy), 32'd0);

    // Products offered in IDLE are refused and not summed.
    bus.prod_valid = 1'b1;
    bus.prod       = 8'd99;
    chk("idle prod_ready", 32'(bus.prod_ready), 32'd0);
    tick();
    tick();
    bus.prod_valid = 1'b0;
    chk("idle res_unchanged", 32'(bus.res), 32'd11);
    chk("idle busy", 32'(bus.busy), 32'd0);

    // Asynchronous reset partway through a run that has already overflowed.
    start_run(4'd8);
    for (int i = 0; i < 5; i++) beat(8'd255);
    chk("arst ovf_before", 32'(bus.ovf), 32'd1);
    chk("arst busy_before", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst prod_ready", 32'(bus.prod_ready), 32'd0);
    chk("arst res_valid", 32'(bus.res_valid), 32'd0);
    chk("arst res", 32'(bus.res), 32'd0);
    chk("arst busy", 32'(bus.busy), 32'd0);
    chk("arst ovf", 32'(bus.ovf), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    vecs[0].nt = 4'd1; vecs[0].beats = 1;
    vecs[0].p  = '0;
    vecs[0].p[0] = 8'd7;
    vecs[0].exp_res = 10'd7; vecs[0].exp_ovf = 1'b0;
    run_vec(vecs[0], 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
